// File: rtl/data_bus_demux_pkg.sv
// data_bus_pkg: shared IDs, widths and default address map for the data-bus demux.
package data_bus_pkg;

    // IDs are sized for the largest supported device count plus the error target.
    localparam int MAX_NUM_DEV = 8;
    localparam int DEV_ID_W    = $clog2(MAX_NUM_DEV + 1);

    typedef logic [DEV_ID_W-1:0] dev_id_t;

    // Default processor_block map: dev0 = RAM at 0x1xxx_xxxx, dev1 = debug at 0x2xxx_xxxx.
    localparam int PB_NUM_DEV = 2;
    localparam logic [PB_NUM_DEV-1:0][31:0] PB_DEV_BASE = {32'h2000_0000, 32'h1000_0000};
    localparam logic [PB_NUM_DEV-1:0][31:0] PB_DEV_MASK = {32'hF000_0000, 32'hF000_0000};

    // The internal decode-error responder always takes the ID one past the last device.
    function automatic dev_id_t err_id(input int num_dev);
        return dev_id_t'(num_dev);
    endfunction

endpackage

// File: rtl/data_bus_addr_decode.sv
// data_bus_addr_decode: address map compare and lowest-index priority select.
module data_bus_addr_decode
    import data_bus_pkg::*;
#(
    parameter int                         NUM_DEV  = PB_NUM_DEV,
    parameter logic [NUM_DEV-1:0][31:0]   DEV_BASE = PB_DEV_BASE,
    parameter logic [NUM_DEV-1:0][31:0]   DEV_MASK = PB_DEV_MASK
) (
    input  logic [31:0] addr_i,
    output dev_id_t     sel_o
);

    logic [NUM_DEV-1:0] hit;

    // Walk from the top index down so the lowest hitting device wins.
    always_comb begin
        hit   = '0;
        sel_o = err_id(NUM_DEV);
        for (int i = NUM_DEV - 1; i >= 0; i--) begin
            hit[i] = (addr_i & DEV_MASK[i]) == DEV_BASE[i];
            sel_o  = hit[i] ? dev_id_t'(i) : sel_o;
        end
    end

endmodule

// File: rtl/data_bus_demux.sv
// data_bus_demux: core data port to NUM_DEV devices with in-order outstanding tracking;
// optional decode-error logging outputs when DATA_BUS_DEMUX_ERR_LOG_EN is defined.
module data_bus_demux
    import data_bus_pkg::*;
#(
    parameter int                         NUM_DEV         = PB_NUM_DEV,
    parameter logic [NUM_DEV-1:0][31:0]   DEV_BASE        = PB_DEV_BASE,
    parameter logic [NUM_DEV-1:0][31:0]   DEV_MASK        = PB_DEV_MASK,
    parameter int                         MAX_OUTSTANDING = 2,
    parameter logic [6:0]                 ERR_RDATA_INTG  = 7'h00
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         data_req_i,
    input  logic                         data_we_i,
    input  logic [3:0]                   data_be_i,
    input  logic [31:0]                  data_addr_i,
    input  logic [31:0]                  data_wdata_i,
    input  logic [6:0]                   data_wdata_intg_i,
    output logic                         data_gnt_o,
    output logic                         data_rvalid_o,
    output logic                         data_err_o,
    output logic [31:0]                  data_rdata_o,
    output logic [6:0]                   data_rdata_intg_o,
    output logic [NUM_DEV-1:0]           dev_req_o,
    output logic                         dev_we_o,
    output logic [3:0]                   dev_be_o,
    output logic [31:0]                  dev_addr_o,
    output logic [31:0]                  dev_wdata_o,
    output logic [6:0]                   dev_wdata_intg_o,
    input  logic [NUM_DEV-1:0]           dev_gnt_i,
    input  logic [NUM_DEV-1:0]           dev_rvalid_i,
    input  logic [NUM_DEV-1:0]           dev_err_i,
    input  logic [NUM_DEV-1:0][31:0]     dev_rdata_i,
    input  logic [NUM_DEV-1:0][6:0]      dev_rdata_intg_i
`ifdef DATA_BUS_DEMUX_ERR_LOG_EN
    ,
    output logic [31:0]                  err_addr_o,
    output logic                         err_sticky_o
`endif
);

    localparam int      CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam dev_id_t ERR_ID = err_id(NUM_DEV);

    dev_id_t          sel;
    dev_id_t          out_sel_q, out_sel_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             err_pend_q, err_pend_d;
    logic             can_issue, sel_gnt, accept;
    logic             tgt_rvalid, tgt_err, rsp;
    logic [31:0]      tgt_rdata;
    logic [6:0]       tgt_intg;

    data_bus_addr_decode #(
        .NUM_DEV  (NUM_DEV),
        .DEV_BASE (DEV_BASE),
        .DEV_MASK (DEV_MASK)
    ) u_decode (
        .addr_i (data_addr_i),
        .sel_o  (sel)
    );

    assign dev_we_o         = data_we_i;
    assign dev_be_o         = data_be_i;
    assign dev_addr_o       = data_addr_i;
    assign dev_wdata_o      = data_wdata_i;
    assign dev_wdata_intg_o = data_wdata_intg_i;

    // Issue only to the current target (or anything once drained) so responses stay in order.
    always_comb begin
        can_issue = !rst && ((out_cnt_q == '0) ||
                    (out_cnt_q < CNT_W'(MAX_OUTSTANDING) && sel == out_sel_q));
        sel_gnt   = sel == ERR_ID;
        dev_req_o = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            sel_gnt      = (sel == dev_id_t'(i)) ? dev_gnt_i[i] : sel_gnt;
            dev_req_o[i] = data_req_i && can_issue && sel == dev_id_t'(i);
        end
        data_gnt_o = data_req_i && can_issue && sel_gnt;
        accept     = data_gnt_o;
    end

    // Route the response of the owning target; the error responder answers one cycle after accept.
    always_comb begin
        tgt_rvalid = 1'b0;
        tgt_err    = 1'b0;
        tgt_rdata  = '0;
        tgt_intg   = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            tgt_rvalid = (out_sel_q == dev_id_t'(i)) ? dev_rvalid_i[i]     : tgt_rvalid;
            tgt_err    = (out_sel_q == dev_id_t'(i)) ? dev_err_i[i]        : tgt_err;
            tgt_rdata  = (out_sel_q == dev_id_t'(i)) ? dev_rdata_i[i]      : tgt_rdata;
            tgt_intg   = (out_sel_q == dev_id_t'(i)) ? dev_rdata_intg_i[i] : tgt_intg;
        end
        tgt_rvalid        = (out_sel_q == ERR_ID) ? err_pend_q     : tgt_rvalid;
        tgt_err           = (out_sel_q == ERR_ID) ? 1'b1           : tgt_err;
        tgt_intg          = (out_sel_q == ERR_ID) ? ERR_RDATA_INTG : tgt_intg;
        tgt_rdata         = (out_sel_q == ERR_ID) ? 32'h0          : tgt_rdata;
        rsp               = !rst && out_cnt_q != '0 && tgt_rvalid;
        data_rvalid_o     = rsp;
        data_err_o        = rsp && tgt_err;
        data_rdata_o      = rsp ? tgt_rdata : 32'h0;
        data_rdata_intg_o = rsp ? tgt_intg : 7'h0;
    end

    // Outstanding count moves by accept minus response; target latches on every accept.
    always_comb begin
        out_sel_d  = accept ? sel : out_sel_q;
        out_cnt_d  = out_cnt_q + CNT_W'(accept) - CNT_W'(rsp);
        err_pend_d = accept && sel == ERR_ID;
    end

    // Tracking state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_sel_q  <= '0;
            out_cnt_q  <= '0;
            err_pend_q <= 1'b0;
        end else begin
            out_sel_q  <= out_sel_d;
            out_cnt_q  <= out_cnt_d;
            err_pend_q <= err_pend_d;
        end
    end

`ifdef DATA_BUS_DEMUX_ERR_LOG_EN
    logic [31:0] err_addr_q, err_addr_d;
    logic        err_sticky_q, err_sticky_d;

    // Remember the last unmapped address and that any decode error happened.
    always_comb begin
        err_addr_d   = err_pend_d ? data_addr_i : err_addr_q;
        err_sticky_d = err_sticky_q || err_pend_d;
    end

    // Error log registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_addr_q   <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            err_addr_q   <= err_addr_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign err_addr_o   = err_addr_q;
    assign err_sticky_o = err_sticky_q;
`else
    // Without logging the error responder keeps no address history.
`endif

endmodule

// File: tb/tb_data_bus_demux.sv
// tb_data_bus_demux: scoreboard bench for the data-bus demux default build.
module tb_data_bus_demux;

    localparam int         ND       = 2;
    localparam logic [6:0] ERR_INTG = 7'h5A;

    typedef struct packed {
        logic [31:0] rdata;
        logic [6:0]  intg;
        logic        err;
    } rsp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                data_req_i, data_we_i;
    logic [3:0]          data_be_i;
    logic [31:0]         data_addr_i, data_wdata_i;
    logic [6:0]          data_wdata_intg_i;
    logic                data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0]         data_rdata_o;
    logic [6:0]          data_rdata_intg_o;
    logic [ND-1:0]       dev_req_o;
    logic                dev_we_o;
    logic [3:0]          dev_be_o;
    logic [31:0]         dev_addr_o, dev_wdata_o;
    logic [6:0]          dev_wdata_intg_o;
    logic [ND-1:0]       dev_gnt_i, dev_rvalid_i, dev_err_i;
    logic [ND-1:0][31:0] dev_rdata_i;
    logic [ND-1:0][6:0]  dev_rdata_intg_i;

    rsp_t sb[$];
    rsp_t exp_r;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    data_bus_demux #(
        .NUM_DEV         (ND),
        .DEV_BASE        ({32'h2000_0000, 32'h1000_0000}),
        .DEV_MASK        ({32'hF000_0000, 32'hF000_0000}),
        .MAX_OUTSTANDING (2),
        .ERR_RDATA_INTG  (ERR_INTG)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .data_req_i        (data_req_i),
        .data_we_i         (data_we_i),
        .data_be_i         (data_be_i),
        .data_addr_i       (data_addr_i),
        .data_wdata_i      (data_wdata_i),
        .data_wdata_intg_i (data_wdata_intg_i),
        .data_gnt_o        (data_gnt_o),
        .data_rvalid_o     (data_rvalid_o),
        .data_err_o        (data_err_o),
        .data_rdata_o      (data_rdata_o),
        .data_rdata_intg_o (data_rdata_intg_o),
        .dev_req_o         (dev_req_o),
        .dev_we_o          (dev_we_o),
        .dev_be_o          (dev_be_o),
        .dev_addr_o        (dev_addr_o),
        .dev_wdata_o       (dev_wdata_o),
        .dev_wdata_intg_o  (dev_wdata_intg_o),
        .dev_gnt_i         (dev_gnt_i),
        .dev_rvalid_i      (dev_rvalid_i),
        .dev_err_i         (dev_err_i),
        .dev_rdata_i       (dev_rdata_i),
        .dev_rdata_intg_i  (dev_rdata_intg_i)
    );

    // Host-side response monitor: pop the scoreboard on every rvalid, otherwise expect zeros.
    always @(negedge clk) begin
        n_cmp++;
        if (data_rvalid_o) begin
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected_rvalid got rdata=%h err=%b, required no response", data_rdata_o, data_err_o);
            end else begin
                exp_r = sb.pop_front();
                if ({data_rdata_o, data_rdata_intg_o, data_err_o} !== exp_r) begin
                    n_bad++;
                    $display("FAIL sb_response got rdata=%h intg=%h err=%b, required rdata=%h intg=%h err=%b",
                             data_rdata_o, data_rdata_intg_o, data_err_o, exp_r.rdata, exp_r.intg, exp_r.err);
                end
            end
        end else if ({data_rdata_o, data_rdata_intg_o, data_err_o} !== 40'h0) begin
            n_bad++;
            $display("FAIL idle_outputs got rdata=%h intg=%h err=%b, required all zero",
                     data_rdata_o, data_rdata_intg_o, data_err_o);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1);
    end

    task automatic idle();
        data_req_i        = 1'b0;
        data_we_i         = 1'b0;
        data_be_i         = 4'hF;
        data_addr_i       = 32'h0;
        data_wdata_i      = 32'h0;
        data_wdata_intg_i = 7'h0;
        dev_gnt_i         = '0;
        dev_rvalid_i      = '0;
        dev_err_i         = '0;
        dev_rdata_i       = '0;
        dev_rdata_intg_i  = '0;
    endtask

    task automatic req(input logic we, input logic [31:0] a);
        data_req_i   = 1'b1;
        data_we_i    = we;
        data_addr_i  = a;
        data_wdata_i = a ^ 32'h5A5A_5A5A;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        req(1'b0, 32'h1000_0000);
        dev_gnt_i    = 2'b11;
        dev_rvalid_i = 2'b11;
        repeat (3) @(posedge clk);
        smp();
        n_cmp++;
        if (data_gnt_o !== 1'b0 || dev_req_o !== 2'b00 || data_rvalid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs got gnt=%b req=%b rvalid=%b, required 0/00/0", data_gnt_o, dev_req_o, data_rvalid_o);
        end
        nxt();
        rst = 1'b0;
        smp();
        n_cmp++;
        if (data_gnt_o !== 1'b0 || dev_req_o !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_idle got gnt=%b req=%b, required 0/00", data_gnt_o, dev_req_o);
        end
    endtask

    task automatic test_read();
        nxt();
        req(1'b0, 32'h1000_0004);
        dev_gnt_i = 2'b01;
        smp();
        n_cmp++;
        if (data_gnt_o !== 1'b1 || dev_req_o !== 2'b01 || dev_addr_o !== 32'h1000_0004) begin
            n_bad++;
            $display("FAIL read_issue got gnt=%b req=%b addr=%h, required 1/01/10000004", data_gnt_o, dev_req_o, dev_addr_o);
        end
        if (data_gnt_o) sb.push_back('{32'hDEAD_BEEF, 7'h2A, 1'b0});
        nxt();
        smp();
        n_cmp++;
        if (data_rvalid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL read_wait got rvalid=%b, required 0", data_rvalid_o);
        end
        nxt();
        dev_rvalid_i        = 2'b01;
        dev_rdata_i[0]      = 32'hDEAD_BEEF;
        dev_rdata_intg_i[0] = 7'h2A;
        dev_rdata_i[1]      = 32'h1111_1111;
        smp();
        n_cmp++;
        if (data_rvalid_o !== 1'b1) begin
            n_bad++;
            $display("FAIL read_rvalid got rvalid=%b, required 1", data_rvalid_o);
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 5; c++) begin
            nxt();
            req(1'b1, 32'h2000_0000);
            dev_gnt_i = 2'b10;
            if (c == 3) begin
                dev_rvalid_i        = 2'b10;
                dev_rdata_i[1]      = 32'h0000_0001;
                dev_rdata_intg_i[1] = 7'h01;
            end
            smp();
            n_cmp++;
            if ((c == 2 || c == 3) ? (data_gnt_o !== 1'b0 || dev_req_o !== 2'b00)
                                   : (data_gnt_o !== 1'b1 || dev_req_o !== 2'b10 || dev_we_o !== 1'b1)) begin
                n_bad++;
                $display("FAIL b2b_issue cycle %0d got gnt=%b req=%b we=%b, required stall=%0d",
                         c, data_gnt_o, dev_req_o, dev_we_o, (c == 2 || c == 3));
            end
            if (data_gnt_o) sb.push_back('{32'(c == 4 ? 3 : c + 1), 7'(c == 4 ? 3 : c + 1), c == 1});
        end
        for (int c = 2; c <= 3; c++) begin
            nxt();
            dev_rvalid_i        = 2'b10;
            dev_err_i           = (c == 2) ? 2'b10 : 2'b00;
            dev_rdata_i[1]      = 32'(c);
            dev_rdata_intg_i[1] = 7'(c);
            smp();
        end
        nxt();
        smp();
    endtask

    task automatic test_switch();
        nxt();
        req(1'b0, 32'h1000_0010);
        dev_gnt_i = 2'b01;
        smp();
        n_cmp++;
        if (data_gnt_o !== 1'b1) begin
            n_bad++;
            $display("FAIL switch_first got gnt=%b, required 1", data_gnt_o);
        end
        if (data_gnt_o) sb.push_back('{32'hA0A0_0001, 7'h11, 1'b0});
        for (int c = 0; c < 3; c++) begin
            nxt();
            req(1'b0, 32'h2000_0010);
            dev_gnt_i = 2'b11;
            if (c == 1) begin
                dev_rvalid_i        = 2'b01;
                dev_rdata_i[0]      = 32'hA0A0_0001;
                dev_rdata_intg_i[0] = 7'h11;
            end
            smp();
            n_cmp++;
            if ((c < 2) ? (dev_req_o !== 2'b00 || data_gnt_o !== 1'b0)
                        : (dev_req_o !== 2'b10 || data_gnt_o !== 1'b1)) begin
                n_bad++;
                $display("FAIL switch_hold cycle %0d got req=%b gnt=%b, required %s", c, dev_req_o, data_gnt_o,
                         (c < 2) ? "00/0" : "10/1");
            end
            if (data_gnt_o) sb.push_back('{32'hB0B0_0002, 7'h22, 1'b0});
        end
        nxt();
        dev_rvalid_i        = 2'b11;
        dev_rdata_i[0]      = 32'hEEEE_EEEE;
        dev_rdata_i[1]      = 32'hB0B0_0002;
        dev_rdata_intg_i[1] = 7'h22;
        dev_err_i           = 2'b01;
        smp();
    endtask

    task automatic test_spurious();
        for (int c = 0; c < 2; c++) begin
            nxt();
            dev_rvalid_i   = (c == 0) ? 2'b10 : 2'b11;
            dev_rdata_i[1] = 32'h0000_0BAD;
            smp();
            n_cmp++;
            if (data_rvalid_o !== 1'b0) begin
                n_bad++;
                $display("FAIL spurious_rvalid got rvalid=%b, required 0", data_rvalid_o);
            end
        end
        for (int c = 0; c < 2; c++) begin
            nxt();
            req(1'b0, 32'h2000_0020);
            dev_gnt_i = 2'b10;
            smp();
            n_cmp++;
            if (data_gnt_o !== 1'b1) begin
                n_bad++;
                $display("FAIL spurious_cnt_idle got gnt=%b, required 1", data_gnt_o);
            end
            if (data_gnt_o) sb.push_back('{32'hC000_0001 + 32'(c), 7'h31 + 7'(c), 1'b0});
        end
        for (int c = 0; c < 2; c++) begin
            nxt();
            dev_rvalid_i        = 2'b10;
            dev_rdata_i[1]      = 32'hC000_0001 + 32'(c);
            dev_rdata_intg_i[1] = 7'h31 + 7'(c);
            smp();
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] addrs [3];
        addrs[0] = 32'h5000_0000;
        addrs[1] = 32'h5000_0004;
        addrs[2] = 32'h8000_0000;
        for (int c = 0; c < 3; c++) begin
            nxt();
            req(c == 2, addrs[c]);
            dev_gnt_i = 2'b11;
            smp();
            n_cmp++;
            if (data_gnt_o !== 1'b1 || dev_req_o !== 2'b00) begin
                n_bad++;
                $display("FAIL unmapped_issue addr %h got gnt=%b req=%b, required 1/00", addrs[c], data_gnt_o, dev_req_o);
            end
            if (data_gnt_o) sb.push_back('{32'h0, ERR_INTG, 1'b1});
        end
        nxt();
        smp();
        n_cmp++;
        if (data_rvalid_o !== 1'b1 || data_err_o !== 1'b1) begin
            n_bad++;
            $display("FAIL unmapped_resp got rvalid=%b err=%b, required 1/1", data_rvalid_o, data_err_o);
        end
        nxt();
        smp();
        n_cmp++;
        if (data_rvalid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL unmapped_drain got rvalid=%b, required 0", data_rvalid_o);
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 2; c++) begin
            nxt();
            req(1'b0, 32'h1000_0040);
            dev_gnt_i = 2'b01;
            smp();
            if (data_gnt_o) sb.push_back('{32'h0, 7'h0, 1'b0});
        end
        nxt();
        rst = 1'b1;
        smp();
        sb.delete();
        n_cmp++;
        if (data_rvalid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_during got rvalid=%b, required 0", data_rvalid_o);
        end
        for (int c = 0; c < 2; c++) begin
            nxt();
            rst                 = 1'b0;
            dev_rvalid_i        = 2'b01;
            dev_rdata_i[0]      = 32'h0000_0BAD;
            smp();
            n_cmp++;
            if (data_rvalid_o !== 1'b0) begin
                n_bad++;
                $display("FAIL rstmid_late_rvalid got rvalid=%b, required 0", data_rvalid_o);
            end
        end
        nxt();
        req(1'b0, 32'h1000_0044);
        dev_gnt_i = 2'b01;
        smp();
        n_cmp++;
        if (data_gnt_o !== 1'b1 || dev_req_o !== 2'b01) begin
            n_bad++;
            $display("FAIL rstmid_reissue got gnt=%b req=%b, required 1/01", data_gnt_o, dev_req_o);
        end
        if (data_gnt_o) sb.push_back('{32'hD000_000D, 7'h4D, 1'b0});
        nxt();
        dev_rvalid_i        = 2'b01;
        dev_rdata_i[0]      = 32'hD000_000D;
        dev_rdata_intg_i[0] = 7'h4D;
        smp();
        n_cmp++;
        if (data_rvalid_o !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_resp got rvalid=%b, required 1", data_rvalid_o);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_back_to_back();
        test_switch();
        test_spurious();
        test_unmapped();
        test_reset_mid();
        nxt();
        smp();
        n_cmp++;
        if (sb.size() !== 0) begin
            n_bad++;
            $display("FAIL sb_drained got %0d pending, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
